fix_accum: RTL and testbench
============================

FIX_ACCUM -- requirements
Module: fix_accum

Interface
REQ-001 Parameter DATA_W, default 32, width of fixed-point input and output samples (signed two's complement).
REQ-002 Parameter ACC_W, default 40, internal accumulator width; SHALL be at least DATA_W+8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 src_valid  input  1  fixed-point sample present on src this cycle (float2fix dst_valid); no backpressure.
REQ-006 src  input  DATA_W  signed fixed-point sample (float2fix dst).
REQ-007 cfg_len  input  8  samples per block; 0 encodes 256; sampled only at block start.
REQ-008 dst_valid  output  1  saturated block sum held on dst.
REQ-009 dst_ready  input  1  consumer accepts dst when dst_valid && dst_ready.
REQ-010 dst  output  DATA_W  saturated block sum.
REQ-011 dst_sat  output  1  dst was clipped; qualified by dst_valid.
REQ-012 ovf_err  output  1  sticky flag, a completed block was dropped.

Function
REQ-013 FSM states: IDLE (no block open) and ACC (block open); output register is independent of FSM.
REQ-014 IDLE + src_valid: latch len = (cfg_len==0 ? 256 : cfg_len) into 9-bit register, acc = sign-extended src, cnt = 1; go to ACC, or complete block this cycle if len==1.
REQ-015 ACC + src_valid: acc += sign-extended src, cnt += 1; when new cnt == len, block completes this cycle and FSM returns to IDLE.
REQ-016 ACC without src_valid: hold acc, cnt, state; no timeout.
REQ-017 Block completion: final sum (including the completing sample) saturated to DATA_W and presented on dst with dst_valid=1 on the next cycle (latency 1 cycle after last sample).
REQ-018 Saturation: sum > 2^(DATA_W-1)-1 -> 0x7FFFFFFF, dst_sat=1; sum < -2^(DATA_W-1) -> 0x80000000, dst_sat=1; else exact low DATA_W bits, dst_sat=0.
REQ-019 ACC_W SHALL never wrap internally for 256 samples of full-scale input.
REQ-020 Output register: dst_valid clears after a handshake unless a new result loads the same cycle; dst, dst_sat stable while dst_valid && !dst_ready.
REQ-021 Completion while output register holds an unaccepted result and dst_ready=0: new result dropped, old result kept, ovf_err set.
REQ-022 Completion in same cycle as handshake (dst_valid && dst_ready): new result loads, dst_valid stays 1, no error.
REQ-023 Accumulation continues back-to-back: sample arriving the cycle after completion starts a new block from IDLE with fresh cfg_len.
REQ-024 cfg_len changes mid-block SHALL have no effect on the open block.

Reset
REQ-025 rst=1 at a rising edge: state=IDLE, acc=0, cnt=0, len=0, dst_valid=0, dst=0, dst_sat=0, ovf_err=0.
REQ-026 Reset mid-block discards the partial sum; src_valid during reset ignored.
REQ-027 ovf_err clears only on reset.

Structure
REQ-028 Package fix_accum_pkg holds DATA_W/ACC_W defaults, SAT_MAX/SAT_MIN constants and the state enumeration.
REQ-029 One sub-module, fix_sat: combinational ACC_W->DATA_W saturator producing value and sat flag.
REQ-030 Single always-block for sequential state; no latches; no combinational path src->dst.

Verification
REQ-031 cfg_len=4, src=1,2,3,4 consecutive, dst_ready=1 -> one cycle after 4th sample dst=10, dst_valid=1 one cycle, dst_sat=0.
REQ-032 cfg_len=2, src=0x7FFFFFFF twice -> dst=0x7FFFFFFF, dst_sat=1; src=0x80000000 twice -> dst=0x80000000, dst_sat=1.
REQ-033 cfg_len=1, dst_ready=0, src=5 then src=7 -> dst holds 5, ovf_err=1; then dst_ready=1 -> handshake on 5, dst_valid=0.
REQ-034 cfg_len=1, dst_ready=1, src=5,7,9 back-to-back -> dst 5,7,9 on consecutive cycles, dst_valid continuously 1, ovf_err=0.
REQ-035 cfg_len=0, 256 samples of 1 with gaps -> dst=256; cfg_len changed to 3 mid-block has no effect.
REQ-036 cfg_len=4, 2 samples then rst=1 one cycle, then samples 1,1,1,1 -> dst=4, ovf_err=0, no partial result emitted.

Source files
------------

// File: rtl/fix_accum_pkg.sv
// Shared widths, saturation limits and FSM encoding for the fixed-point block accumulator.
package fix_accum_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ACC_W  = 40;
    localparam int LEN_W      = 9;

    localparam logic [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/fix_accum_if.sv
// Sample stream in, block-sum stream out; master is the environment, slave is the accumulator.
interface fix_accum_if #(
    parameter int DATA_W = fix_accum_pkg::DEF_DATA_W
);
    logic              src_valid;
    logic [DATA_W-1:0] src;
    logic [7:0]        cfg_len;
    logic              dst_valid;
    logic              dst_ready;
    logic [DATA_W-1:0] dst;
    logic              dst_sat;

    modport master (
        output src_valid, src, cfg_len, dst_ready,
        input  dst_valid, dst, dst_sat
    );

    modport slave (
        input  src_valid, src, cfg_len, dst_ready,
        output dst_valid, dst, dst_sat
    );
endinterface

// File: rtl/fix_sat.sv
// Clamp a signed ACC_W accumulator to signed DATA_W and flag when clipping occurred.
// Latency: purely combinational.
// Backpressure: none.
module fix_sat #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] dat,
    output logic              sat
);

    localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    // Value fits when every bit above the DATA_W sign bit matches that sign bit.
    logic [ACC_W-DATA_W:0] top_bits;
    logic                  in_range;

    assign top_bits = acc[ACC_W-1:DATA_W-1];
    assign in_range = (&top_bits) | (~|top_bits);

    always_comb begin
        sat = ~in_range;
        dat = acc[DATA_W-1:0];
        if (!in_range) begin
            dat = acc[ACC_W-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/fix_accum.sv
// Sums blocks of cfg_len signed samples and emits each saturated block sum.
// Latency: result valid 1 cycle after the block's last sample.
// Backpressure: none on src; a result completing while dst is stalled is dropped and ovf_err set.
module fix_accum
    import fix_accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic       clk,
    input  logic       rst,
    fix_accum_if.slave bus,
    output logic       ovf_err
);

    if (ACC_W < DATA_W + 8) begin : g_bad_acc_w
        $error("fix_accum: ACC_W must be at least DATA_W+8");
    end

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len;

    logic [ACC_W-1:0]  src_ext;
    logic [ACC_W-1:0]  acc_nxt;
    logic [LEN_W-1:0]  cnt_nxt;
    logic [LEN_W-1:0]  len_cur;
    logic              blk_done;
    logic              out_free;
    logic [DATA_W-1:0] sat_dat;
    logic              sat_flg;

    assign src_ext = {{(ACC_W-DATA_W){bus.src[DATA_W-1]}}, bus.src};

    // A sample seen in IDLE opens a block and captures the length for its whole lifetime.
    always_comb begin
        acc_nxt = acc + src_ext;
        cnt_nxt = cnt + 9'd1;
        len_cur = len;
        if (state == ST_IDLE) begin
            acc_nxt = src_ext;
            cnt_nxt = 9'd1;
            len_cur = (bus.cfg_len == 8'd0) ? 9'd256 : {1'b0, bus.cfg_len};
        end
    end

    assign blk_done = bus.src_valid && (cnt_nxt == len_cur);
    assign out_free = !bus.dst_valid || bus.dst_ready;

    fix_sat #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sat (
        .acc (acc_nxt),
        .dat (sat_dat),
        .sat (sat_flg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            acc           <= '0;
            cnt           <= '0;
            len           <= '0;
            bus.dst_valid <= 1'b0;
            bus.dst       <= '0;
            bus.dst_sat   <= 1'b0;
            ovf_err       <= 1'b0;
        end else begin
            if (bus.src_valid) begin
                acc   <= acc_nxt;
                cnt   <= cnt_nxt;
                len   <= len_cur;
                state <= blk_done ? ST_IDLE : ST_ACC;
            end

            // Output register: a fresh result may replace one being accepted this same cycle.
            if (blk_done && out_free) begin
                bus.dst_valid <= 1'b1;
                bus.dst       <= sat_dat;
                bus.dst_sat   <= sat_flg;
            end else begin
                if (blk_done) begin
                    ovf_err <= 1'b1;
                end
                if (bus.dst_valid && bus.dst_ready) begin
                    bus.dst_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fix_accum.sv
module tb_fix_accum;

    logic clk;
    logic rst;
    logic ovf_err;

    int n_vec;
    int n_err;

    fix_accum_if #(.DATA_W(32)) bus ();

    fix_accum #(
        .DATA_W (32),
        .ACC_W  (40)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ovf_err (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        v;
        logic [31:0] s;
        logic [7:0]  len;
        logic        rdy;
        logic        exp_vld;
        logic [31:0] exp_dst;
        logic        exp_sat;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic v, input logic [31:0] s, input logic [7:0] len,
                                input logic rdy, input logic ev, input logic [31:0] ed,
                                input logic es);
        vec_t r;
        r.v = v; r.s = s; r.len = len; r.rdy = rdy;
        r.exp_vld = ev; r.exp_dst = ed; r.exp_sat = es;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] s, input logic [7:0] l, input logic r);
        bus.src_valid = v;
        bus.src       = s;
        bus.cfg_len   = l;
        bus.dst_ready = r;
        @(posedge clk);
        #1;
    endtask

    // n back-to-back samples of val, flagging any result that appears before the last one.
    task automatic run_block(input int n, input logic [31:0] val, input logic [7:0] l,
                             output int early);
        early = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, val, l, 1'b1);
            if (i < n - 1 && bus.dst_valid) early++;
        end
    endtask

    initial begin
        int early;
        n_vec = 0;
        n_err = 0;

        // Block sums, saturation edges, back-to-back 1-sample blocks, fresh cfg_len per block.
        vecs[0]  = mk(1, 32'd1,        8'd4, 1, 0, 32'd0,        0);
        vecs[1]  = mk(1, 32'd2,        8'd4, 1, 0, 32'd0,        0);
        vecs[2]  = mk(1, 32'd3,        8'd4, 1, 0, 32'd0,        0);
        vecs[3]  = mk(1, 32'd4,        8'd4, 1, 1, 32'd10,       0);
        vecs[4]  = mk(0, 32'd0,        8'd4, 1, 0, 32'd0,        0);
        vecs[5]  = mk(1, 32'h7FFFFFFF, 8'd2, 1, 0, 32'd0,        0);
        vecs[6]  = mk(1, 32'h7FFFFFFF, 8'd2, 1, 1, 32'h7FFFFFFF, 1);
        vecs[7]  = mk(1, 32'h80000000, 8'd2, 1, 0, 32'd0,        0);
        vecs[8]  = mk(1, 32'h80000000, 8'd2, 1, 1, 32'h80000000, 1);
        vecs[9]  = mk(0, 32'd0,        8'd2, 1, 0, 32'd0,        0);
        vecs[10] = mk(1, 32'hFFFFFFFD, 8'd2, 1, 0, 32'd0,        0);
        vecs[11] = mk(1, 32'd1,        8'd2, 1, 1, 32'hFFFFFFFE, 0);
        vecs[12] = mk(1, 32'h7FFFFFFE, 8'd2, 1, 0, 32'd0,        0);
        vecs[13] = mk(1, 32'd1,        8'd2, 1, 1, 32'h7FFFFFFF, 0);
        vecs[14] = mk(1, 32'h80000001, 8'd2, 1, 0, 32'd0,        0);
        vecs[15] = mk(1, 32'hFFFFFFFF, 8'd2, 1, 1, 32'h80000000, 0);
        vecs[16] = mk(0, 32'd0,        8'd2, 1, 0, 32'd0,        0);
        vecs[17] = mk(1, 32'd5,        8'd1, 1, 1, 32'd5,        0);
        vecs[18] = mk(1, 32'd7,        8'd1, 1, 1, 32'd7,        0);
        vecs[19] = mk(1, 32'd9,        8'd1, 1, 1, 32'd9,        0);
        vecs[20] = mk(0, 32'd0,        8'd1, 1, 0, 32'd0,        0);
        vecs[21] = mk(1, 32'd1,        8'd2, 1, 0, 32'd0,        0);
        vecs[22] = mk(1, 32'd1,        8'd2, 1, 1, 32'd2,        0);
        vecs[23] = mk(1, 32'd2,        8'd3, 1, 0, 32'd0,        0);
        vecs[24] = mk(1, 32'd2,        8'd1, 1, 0, 32'd0,        0);
        vecs[25] = mk(1, 32'd2,        8'd1, 1, 1, 32'd6,        0);
        vecs[26] = mk(0, 32'd0,        8'd1, 1, 0, 32'd0,        0);

        // Reset with src_valid asserted must leave everything cleared.
        rst = 1'b1;
        cyc(1'b1, 32'd5, 8'd1, 1'b1);
        cyc(1'b1, 32'd5, 8'd1, 1'b1);
        chk("reset dst_valid", {31'd0, bus.dst_valid}, 32'd0);
        chk("reset dst",       bus.dst,                32'd0);
        chk("reset dst_sat",   {31'd0, bus.dst_sat},   32'd0);
        chk("reset ovf_err",   {31'd0, ovf_err},       32'd0);
        rst = 1'b0;
        cyc(1'b0, 32'd0, 8'd1, 1'b1);
        chk("idle after reset dst_valid", {31'd0, bus.dst_valid}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].v, vecs[i].s, vecs[i].len, vecs[i].rdy);
            chk($sformatf("vec%0d dst_valid", i), {31'd0, bus.dst_valid}, {31'd0, vecs[i].exp_vld});
            if (vecs[i].exp_vld) begin
                chk($sformatf("vec%0d dst", i),     bus.dst,              vecs[i].exp_dst);
                chk($sformatf("vec%0d dst_sat", i), {31'd0, bus.dst_sat}, {31'd0, vecs[i].exp_sat});
            end
            chk($sformatf("vec%0d ovf_err", i), {31'd0, ovf_err}, 32'd0);
        end

        // Stalled output: second result dropped, first held, error sticky.
        cyc(1'b1, 32'd5, 8'd1, 1'b0);
        chk("stall first dst_valid", {31'd0, bus.dst_valid}, 32'd1);
        chk("stall first dst",       bus.dst,                32'd5);
        chk("stall first ovf_err",   {31'd0, ovf_err},       32'd0);
        cyc(1'b1, 32'd7, 8'd1, 1'b0);
        chk("stall drop dst",        bus.dst,                32'd5);
        chk("stall drop dst_valid",  {31'd0, bus.dst_valid}, 32'd1);
        chk("stall drop ovf_err",    {31'd0, ovf_err},       32'd1);
        cyc(1'b0, 32'd0, 8'd1, 1'b0);
        chk("stall hold dst",        bus.dst,                32'd5);
        chk("stall hold dst_sat",    {31'd0, bus.dst_sat},   32'd0);
        cyc(1'b0, 32'd0, 8'd1, 1'b1);
        chk("stall release dst_valid", {31'd0, bus.dst_valid}, 32'd0);
        chk("stall release ovf_err",   {31'd0, ovf_err},       32'd1);

        // 256-sample block with gaps; cfg_len changed partway must not matter.
        early = 0;
        for (int i = 0; i < 256; i++) begin
            if (i % 3 == 2) begin
                cyc(1'b0, 32'd0, (i >= 100) ? 8'd3 : 8'd0, 1'b1);
                if (bus.dst_valid) early++;
            end
            cyc(1'b1, 32'd1, (i >= 100) ? 8'd3 : 8'd0, 1'b1);
            if (i < 255 && bus.dst_valid) early++;
        end
        chk("len256 early results", early, 0);
        chk("len256 dst_valid", {31'd0, bus.dst_valid}, 32'd1);
        chk("len256 dst",       bus.dst,                32'd256);
        chk("len256 dst_sat",   {31'd0, bus.dst_sat},   32'd0);
        cyc(1'b0, 32'd0, 8'd0, 1'b1);

        // Full-scale 256-sample blocks must clip, not wrap.
        run_block(256, 32'h7FFFFFFF, 8'd0, early);
        chk("fs max early",   early, 0);
        chk("fs max dst",     bus.dst,              32'h7FFFFFFF);
        chk("fs max dst_sat", {31'd0, bus.dst_sat}, 32'd1);
        run_block(256, 32'h80000000, 8'd0, early);
        chk("fs min early",   early, 0);
        chk("fs min dst",     bus.dst,              32'h80000000);
        chk("fs min dst_sat", {31'd0, bus.dst_sat}, 32'd1);
        cyc(1'b0, 32'd0, 8'd0, 1'b1);
        chk("ovf_err sticky", {31'd0, ovf_err}, 32'd1);

        // Reset mid-block discards the partial sum and clears ovf_err.
        cyc(1'b1, 32'd1, 8'd4, 1'b1);
        cyc(1'b1, 32'd1, 8'd4, 1'b1);
        rst = 1'b1;
        cyc(1'b1, 32'd9, 8'd4, 1'b1);
        rst = 1'b0;
        chk("midrst dst_valid", {31'd0, bus.dst_valid}, 32'd0);
        chk("midrst ovf_err",   {31'd0, ovf_err},       32'd0);
        run_block(4, 32'd1, 8'd4, early);
        chk("midrst early",     early, 0);
        chk("midrst out dst_valid", {31'd0, bus.dst_valid}, 32'd1);
        chk("midrst out dst",   bus.dst,                32'd4);
        chk("midrst out ovf_err", {31'd0, ovf_err},     32'd0);
        cyc(1'b0, 32'd0, 8'd4, 1'b1);
        chk("midrst final dst_valid", {31'd0, bus.dst_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
